// File: rtl/compare1024_driver.sv
// Streams two word-wide operand banks into an external iterative comparator.
// Words go out least significant first, and the comparator's final mode is captured.
module compare1024_driver #(
    parameter int unsigned iW = 32,
    parameter int unsigned NW = 32,
    parameter int unsigned TO = 4
) (
    input  logic          iClk,
    input  logic          iReset,
    input  logic          iWrEn,
    input  logic          iWrSel,
    input  logic [4:0]    iWrAddr,
    input  logic [iW-1:0] iWrData,
    input  logic          iStart,
    output logic          oBusy,
    output logic          oDone,
    output logic [1:0]    oResult,
    output logic          oError,
    output logic          oCmpEnable,
    output logic [iW-1:0] oDataX,
    output logic [iW-1:0] oDataY,
    input  logic [1:0]    iMode
);

    localparam int unsigned AW = (NW > 1) ? $clog2(NW) : 1;
    localparam int unsigned CW = $clog2(NW + 1);
    localparam int unsigned WW = (TO > 1) ? $clog2(TO) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StWait,
        StDone
    } stateT;

    stateT         state;
    logic [CW-1:0] cnt;
    logic [WW-1:0] waitCnt;
    logic [iW-1:0] bankX [NW];
    logic [iW-1:0] bankY [NW];

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state      <= StIdle;
            cnt        <= '0;
            waitCnt    <= '0;
            oBusy      <= 1'b0;
            oDone      <= 1'b0;
            oResult    <= 2'b00;
            oError     <= 1'b0;
            oCmpEnable <= 1'b0;
            oDataX     <= '0;
            oDataY     <= '0;
            for (int i = 0; i < int'(NW); i++) begin
                bankX[i] <= '0;
                bankY[i] <= '0;
            end
        end else begin
            oDone <= 1'b0;
            unique case (state)
                StIdle, StDone: begin
                    // The write lands on the same edge as a start, so streaming sees the new word.
                    if (iWrEn && (32'(iWrAddr) < NW)) begin
                        if (iWrSel) begin
                            bankY[AW'(iWrAddr)] <= iWrData;
                        end else begin
                            bankX[AW'(iWrAddr)] <= iWrData;
                        end
                    end
                    if (iStart) begin
                        state      <= StStream;
                        cnt        <= '0;
                        waitCnt    <= '0;
                        oBusy      <= 1'b1;
                        oCmpEnable <= 1'b1;
                        oResult    <= 2'b00;
                        oError     <= 1'b0;
                    end
                end
                StStream: begin
                    if (cnt == CW'(NW)) begin
                        state  <= StWait;
                        oDataX <= '0;
                        oDataY <= '0;
                    end else begin
                        oDataX <= bankX[cnt[AW-1:0]];
                        oDataY <= bankY[cnt[AW-1:0]];
                        cnt    <= cnt + 1'b1;
                    end
                end
                StWait: begin
                    if (iMode != 2'b00) begin
                        oResult    <= iMode;
                        oDone      <= 1'b1;
                        oBusy      <= 1'b0;
                        oCmpEnable <= 1'b0;
                        state      <= StDone;
                    end else if (waitCnt == WW'(TO - 1)) begin
                        oResult    <= 2'b00;
                        oError     <= 1'b1;
                        oDone      <= 1'b1;
                        oBusy      <= 1'b0;
                        oCmpEnable <= 1'b0;
                        state      <= StDone;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_compare1024_driver.sv
// Bench for compare1024_driver: behavioural comparator plus a scoreboard of
// expected result/error/latency, popped on each oDone.
module tb_compare1024_driver;

    localparam int NW = 32;
    localparam int IW = 32;
    localparam int TO = 4;

    logic          iClk = 1'b0;
    logic          iReset, iWrEn, iWrSel, iStart;
    logic [4:0]    iWrAddr;
    logic [IW-1:0] iWrData;
    logic          oBusy, oDone, oError, oCmpEnable;
    logic [1:0]    oResult, iMode;
    logic [IW-1:0] oDataX, oDataY;

    always #5 iClk = ~iClk;

    compare1024_driver #(.iW(IW), .NW(NW), .TO(TO)) dut (
        .iClk(iClk), .iReset(iReset), .iWrEn(iWrEn), .iWrSel(iWrSel),
        .iWrAddr(iWrAddr), .iWrData(iWrData), .iStart(iStart),
        .oBusy(oBusy), .oDone(oDone), .oResult(oResult), .oError(oError),
        .oCmpEnable(oCmpEnable), .oDataX(oDataX), .oDataY(oDataY), .iMode(iMode)
    );

    // Comparator: registers its enable, then takes NW word steps keeping the last unequal result.
    logic cmpEnQ = 1'b0;
    int   step = 0;
    logic lt = 1'b0, gt = 1'b0;
    bit   stubZero = 1'b0;

    always @(posedge iClk) begin
        if (oCmpEnable !== 1'b1) begin
            cmpEnQ <= 1'b0; step <= 0; lt <= 1'b0; gt <= 1'b0;
        end else begin
            cmpEnQ <= 1'b1;
            if (cmpEnQ && step < NW) begin
                step <= step + 1;
                if (oDataX < oDataY) begin lt <= 1'b1; gt <= 1'b0; end
                else if (oDataX > oDataY) begin lt <= 1'b0; gt <= 1'b1; end
            end
        end
    end

    assign iMode = (stubZero || step != NW) ? 2'b00 : (lt ? 2'b10 : (gt ? 2'b01 : 2'b11));

    int cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    logic [31:0] xMem [NW];
    logic [31:0] yMem [NW];

    typedef struct { logic [1:0] res; logic err; int lat; } expT;
    expT sb[$];

    typedef struct {
        string name; logic [31:0] base;
        int xa; logic [31:0] xv; int ya; logic [31:0] yv;
        int xb; logic [31:0] xbv; int yb; logic [31:0] ybv;
        logic [1:0] exp;
    } vecT;
    vecT vec[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic sel, input int addr, input logic [31:0] d);
        iWrEn = 1'b1; iWrSel = sel; iWrAddr = addr[4:0]; iWrData = d;
        @(negedge iClk);
        iWrEn = 1'b0;
        if (sel) yMem[addr] = d; else xMem[addr] = d;
    endtask

    task automatic loadAll(input logic [31:0] base);
        for (int i = 0; i < NW; i++) begin
            wr(1'b0, i, base);
            wr(1'b1, i, base);
        end
    endtask

    task automatic runCompare(input string name, input logic [1:0] res, input logic err,
                              input int lat, input bit disturb, input bit zeroMon);
        expT e;
        int  t0, rel;
        bit  got, nz;
        got = 1'b0; nz = 1'b0; rel = 0;
        iStart = 1'b1;
        sb.push_back('{res, err, lat});
        @(negedge iClk);
        iStart = 1'b0; iWrEn = 1'b0;
        t0 = cyc;
        for (int k = 0; k < 80 && !got; k++) begin
            rel = cyc - t0;
            if (rel == 6) begin
                check({name, " busy"}, 32'(oBusy), 32'd1);
                check({name, " dataX5"}, oDataX, xMem[5]);
                check({name, " dataY5"}, oDataY, yMem[5]);
            end
            if (disturb && rel == 10) begin
                iStart = 1'b1; iWrEn = 1'b1; iWrSel = 1'b0; iWrAddr = 5'd0; iWrData = 32'h5;
            end
            if (disturb && rel == 11) begin
                iStart = 1'b0; iWrEn = 1'b0;
            end
            if (zeroMon && (oDataX != 0 || oDataY != 0)) nz = 1'b1;
            if (oDone === 1'b1) got = 1'b1;
            else @(negedge iClk);
        end
        e = sb.pop_front();
        check({name, " done seen"}, 32'(got), 32'd1);
        if (got) begin
            check({name, " latency"}, rel, e.lat);
            check({name, " result"}, 32'(oResult), 32'(e.res));
            check({name, " error"}, 32'(oError), 32'(e.err));
            check({name, " busy at done"}, 32'(oBusy), 32'd0);
        end
        if (zeroMon) check({name, " data zero"}, 32'(nz), 32'd0);
        @(negedge iClk);
        check({name, " done one cycle"}, 32'(oDone), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, doneCnt;
        iReset = 1'b1; iWrEn = 1'b0; iWrSel = 1'b0; iWrAddr = '0; iWrData = '0; iStart = 1'b0;
        for (int i = 0; i < NW; i++) begin xMem[i] = '0; yMem[i] = '0; end
        repeat (3) @(negedge iClk);
        check("rst busy", 32'(oBusy), 0);
        check("rst done", 32'(oDone), 0);
        check("rst result", 32'(oResult), 0);
        check("rst error", 32'(oError), 0);
        check("rst cmpEnable", 32'(oCmpEnable), 0);
        check("rst dataX", oDataX, 0);
        check("rst dataY", oDataY, 0);
        iReset = 1'b0;
        @(negedge iClk);

        vec[0] = '{"eq_a5", 32'hA5A5A5A5, -1, 0, -1, 0, -1, 0, -1, 0, 2'b11};
        vec[1] = '{"msw_dominates", 32'h12345678, 31, 32'h1, 31, 32'h2, 0, 32'hF, 0, 32'h0, 2'b10};
        vec[2] = '{"w5_gt", 32'h0, 5, 32'h10, 5, 32'h0F, -1, 0, -1, 0, 2'b01};
        vec[3] = '{"lsw_lt", 32'hFFFFFFFF, 0, 32'hFFFFFFFE, -1, 0, -1, 0, -1, 0, 2'b10};
        vec[4] = '{"msw_gt", 32'h0, 31, 32'h80000000, 0, 32'h1, -1, 0, -1, 0, 2'b01};

        for (int v = 0; v < 5; v++) begin
            loadAll(vec[v].base);
            if (vec[v].xa >= 0) wr(1'b0, vec[v].xa, vec[v].xv);
            if (vec[v].ya >= 0) wr(1'b1, vec[v].ya, vec[v].yv);
            if (vec[v].xb >= 0) wr(1'b0, vec[v].xb, vec[v].xbv);
            if (vec[v].yb >= 0) wr(1'b1, vec[v].yb, vec[v].ybv);
            runCompare(vec[v].name, vec[v].exp, 1'b0, NW + 2, 1'b0, 1'b0);
        end

        // Result holds in DONE, comparator disabled, data idle.
        repeat (4) @(negedge iClk);
        check("hold result", 32'(oResult), 32'h1);
        check("hold error", 32'(oError), 0);
        check("hold cmpEnable", 32'(oCmpEnable), 0);
        check("hold busy", 32'(oBusy), 0);
        check("hold dataX", oDataX, 0);

        // Comparator never answers.
        stubZero = 1'b1;
        runCompare("timeout", 2'b00, 1'b1, NW + 1 + TO, 1'b0, 1'b0);
        stubZero = 1'b0;
        repeat (3) @(negedge iClk);
        check("timeout error hold", 32'(oError), 1);

        // Start and write during STREAM are both dropped.
        loadAll(32'h0);
        wr(1'b0, 0, 32'h1);
        wr(1'b1, 0, 32'h2);
        runCompare("busy_ignore", 2'b10, 1'b0, NW + 2, 1'b1, 1'b0);
        doneCnt = 0;
        for (int k = 0; k < 50; k++) begin
            if (oDone === 1'b1) doneCnt++;
            @(negedge iClk);
        end
        check("no requeued run", doneCnt, 0);
        runCompare("bank_unchanged", 2'b10, 1'b0, NW + 2, 1'b0, 1'b0);

        // Write and start together: new word X0=3 > Y0=2.
        iWrEn = 1'b1; iWrSel = 1'b0; iWrAddr = 5'd0; iWrData = 32'h3;
        xMem[0] = 32'h3;
        runCompare("write_with_start", 2'b01, 1'b0, NW + 2, 1'b0, 1'b0);

        // Reset mid-stream at cnt=15.
        loadAll(32'hDEADBEEF);
        iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        t0 = cyc;
        repeat (15) @(negedge iClk);
        check("pre-reset busy", 32'(oBusy), 1);
        iReset = 1'b1;
        @(negedge iClk);
        iReset = 1'b0;
        for (int i = 0; i < NW; i++) begin xMem[i] = '0; yMem[i] = '0; end
        check("abort busy", 32'(oBusy), 0);
        check("abort cmpEnable", 32'(oCmpEnable), 0);
        check("abort done", 32'(oDone), 0);
        doneCnt = 0;
        for (int k = 0; k < 50; k++) begin
            if (oDone === 1'b1) doneCnt++;
            @(negedge iClk);
        end
        check("abort no done", doneCnt, 0);
        runCompare("banks_cleared", 2'b11, 1'b0, NW + 2, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/compare1024_driver.md
COMPARE1024_DRIVER -- requirements
Module: compare1024_driver

Interface
REQ-001 Parameter iW, default 32: operand word width in bits.
REQ-002 Parameter NW, default 32: words per operand; a full operand is iW*NW = 1024 bits.
REQ-003 Parameter TO, default 4: maximum cycles to wait for a non-zero comparator result.
REQ-004 iClk  in  1: the single clock; all logic is on the rising edge.
REQ-005 iReset  in  1: synchronous reset, active-high.
REQ-006 iWrEn  in  1: operand word write strobe.
REQ-007 iWrSel  in  1: operand bank select for a write; 0 = X, 1 = Y.
REQ-008 iWrAddr  in  5: word index; 0 = least significant word.
REQ-009 iWrData  in  iW: word to be written.
REQ-010 iStart  in  1: single-cycle request to run one comparison.
REQ-011 oBusy  out  1: high from the cycle after an accepted start until the cycle oDone pulses.
REQ-012 oDone  out  1: one-cycle pulse when oResult/oError become valid.
REQ-013 oResult  out  2: captured mode; 10 = X<Y, 01 = X>Y, 11 = X==Y, 00 = no result.
REQ-014 oError  out  1: high if the comparator gave no result within TO cycles.
REQ-015 oCmpEnable  out  1: enable to the comparator; low clears the comparator.
REQ-016 oDataX  out  iW: X word presented to the comparator.
REQ-017 oDataY  out  iW: Y word presented to the comparator.
REQ-018 iMode  in  2: combinational mode output of the comparator; 00 until its step count reaches 32.

Function
REQ-019 Storage SHALL be two NW x iW register banks, X and Y, written when iWrEn=1 and the FSM is in IDLE or DONE.
REQ-020 A write SHALL update the selected bank word at iWrAddr on the next edge.
REQ-021 Writes with iWrEn=1 in STREAM or WAIT SHALL be ignored and the banks SHALL be left unchanged.
REQ-022 The FSM states SHALL be IDLE, STREAM, WAIT and DONE.
REQ-023 IDLE/DONE: iStart=1 SHALL move the FSM to STREAM, clear the word counter cnt to 0, set oCmpEnable=1, and clear oError and oResult.
REQ-024 STREAM: oDataX/oDataY SHALL equal bank word cnt, registered so they align with comparator step cnt, for cnt = 0..NW-1, least significant word first.
REQ-025 STREAM: cnt SHALL increment each cycle, and the FSM SHALL move to WAIT after word NW-1 is presented.
REQ-026 The most significant word is sent last because the comparator keeps the last unequal comparison.
REQ-027 WAIT: the first cycle with iMode != 00 SHALL capture iMode into oResult, pulse oDone, drop oCmpEnable to 0 on the next edge, and move the FSM to DONE.
REQ-028 WAIT: if iMode stays 00 for TO cycles, the block SHALL set oResult=00 and oError=1, pulse oDone, drop oCmpEnable, and move the FSM to DONE.
REQ-029 With a matching comparator (REQ-018), oDone SHALL occur NW+2 cycles after the cycle iStart is sampled.
REQ-030 iStart while oBusy=1 SHALL be ignored, with no restart and no queueing.
REQ-031 A write and iStart in the same IDLE cycle SHALL complete the write before streaming, so the new word is used.
REQ-032 oResult and oError SHALL hold their values from DONE until the next accepted iStart or reset.
REQ-033 oDataX/oDataY SHALL be 0 outside STREAM.

Reset
REQ-034 On iReset=1, the FSM SHALL go to IDLE, set cnt=0, drive all outputs to 0, and clear both banks to 0.
REQ-035 A reset during STREAM or WAIT SHALL abort the run with no oDone pulse, and oCmpEnable SHALL go low on the next edge.

Verification
REQ-036 Scenario: X=Y=all words 0xA5A5A5A5, start -> oDone at start+34, oResult=11, oError=0.
REQ-037 Scenario: X=Y except X word 31=0x1, Y word 31=0x2, and X word 0=0xF, Y word 0=0x0 -> oResult=10, since the most significant word dominates.
REQ-038 Scenario: X=Y except X word 5=0x10, Y word 5=0x0F -> oResult=01.
REQ-039 Scenario: stub comparator holding iMode=00 -> oDone at start+NW+1+TO, oResult=00, oError=1.
REQ-040 Scenario: iStart again at cycle 10 of STREAM, plus a write to X word 0 -> both ignored, and the first result matches the pre-start operands.
REQ-041 Scenario: iReset asserted at cnt=15 -> next cycle oBusy=0, oCmpEnable=0, no oDone, and both banks read back 0.
